// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch port and the data port.
// One transaction at a time: arbitrate in IDLE, hold the latched request in BUSY, report in RESP.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate between if_req and d_req on the next edge
//   BUSY  | mem_req high with latched fields; wait for mem_ready (no timeout)
//   RESP  | one-cycle valid pulse to the owner, memory idle
module unified_mem_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_valid,
    output logic                  if_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_sign_mask,
    output logic [31:0]           d_rdata,
    output logic                  d_valid,
    output logic                  d_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_sign_mask,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic       OWNER_FETCH = 1'b0;
    localparam logic       OWNER_DATA  = 1'b1;
    localparam logic [3:0] LIMIT       = 4'(STARVE_LIMIT);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  owner;
    logic [3:0]            starve_cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [31:0]           lat_wdata;
    logic [3:0]            lat_mask;
    logic [31:0]           if_rdata_q;
    logic [31:0]           d_rdata_q;
    logic                  grant_fetch;
    logic                  grant_data;
    logic                  busy;
    logic                  resp;

    assign busy = (state == BUSY);
    assign resp = (state == RESP);

    // Data wins a tie unless the fetch port has already been passed over STARVE_LIMIT times.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state == IDLE) begin
            if (if_req && d_req) begin
                grant_fetch = (starve_cnt == LIMIT);
                grant_data  = (starve_cnt != LIMIT);
            end else begin
                grant_fetch = if_req;
                grant_data  = d_req;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_fetch || grant_data) state_next = BUSY;
            BUSY:    if (mem_ready) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= OWNER_FETCH;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_mask  <= '0;
        end else if (grant_fetch) begin
            owner     <= OWNER_FETCH;
            lat_addr  <= if_addr;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_mask  <= 4'b0000;
        end else if (grant_data) begin
            owner     <= OWNER_DATA;
            lat_addr  <= d_addr;
            lat_we    <= d_we;
            lat_wdata <= d_wdata;
            lat_mask  <= d_sign_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_fetch) begin
            starve_cnt <= '0;
        end else if (grant_data && if_req && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Each port keeps its last word until its own next completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (busy && mem_ready) begin
            if (owner == OWNER_FETCH) begin
                if_rdata_q <= mem_rdata;
            end else begin
                d_rdata_q <= lat_we ? 32'h0 : mem_rdata;
            end
        end
    end

    assign mem_req       = busy;
    assign mem_we        = busy & lat_we;
    assign mem_addr      = lat_addr;
    assign mem_wdata     = lat_wdata;
    assign mem_sign_mask = lat_mask;

    assign if_valid = resp && (owner == OWNER_FETCH);
    assign d_valid  = resp && (owner == OWNER_DATA);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the CPU's instruction-fetch port and data-access port.
- Sits between the cpu top level and the memory subsystem.
- Serialises requests with a registered FSM, latches address and write data for the whole transaction, and returns read data with a one-cycle valid pulse.
- Exports per-port stall signals so the pipeline can freeze while a request is pending.

Parameters:
STARVE_LIMIT, 3, consecutive data grants allowed while a fetch is waiting before a fetch grant is forced (1..15)
ADDR_WIDTH, 32, address width of both ports and the memory

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  32  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle fetch completion pulse
if_stall  out  1  fetch pending and not yet completed
d_req  in  1  data request, level, held until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  32  store data
d_sign_mask  in  4  load/store size and sign mask, passed to memory
d_rdata  out  32  load data, valid with d_valid
d_valid  out  1  one-cycle data completion pulse
d_stall  out  1  data request pending and not yet completed
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  32  memory write data
mem_sign_mask  out  4  memory size and sign mask
mem_ready  in  1  memory completion, sampled only while mem_req=1
mem_rdata  in  32  memory read data, valid when mem_ready=1

Behaviour:
- FSM states: IDLE, BUSY, RESP. Reset value is IDLE.
- Reset values: all outputs 0, starve_cnt 0, owner 0. Reset is asynchronous; asserting it mid-transaction drops mem_req immediately and discards the transaction.
- Arbitration happens only in IDLE, on the rising edge, using if_req and d_req:
  - Neither request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
- On a grant:
  - Latch addr, we, wdata and sign_mask into registers. For a fetch grant, we=0 and sign_mask=4'b0000 (full word).
  - Record the owner and enter BUSY.
- Latched fields are held stable for the whole transaction. Port-side changes to address or data after the grant are ignored.
- BUSY:
  - mem_req=1 and all mem_* outputs are driven from the latch.
  - If mem_ready=1, capture mem_rdata (stores capture 32'h0) and enter RESP.
  - Otherwise stay in BUSY with no timeout.
- RESP:
  - Exactly one cycle with mem_req=0.
  - The owner's valid output is 1 and its rdata output equals the captured word.
  - rdata holds that value until the next completion for the same port.
  - Next state is IDLE.
- Requester rule: drop req on the clock edge that ends the valid cycle. Requests are not sampled in RESP or BUSY.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while if_req=1.
  - Clears on any fetch grant.
  - Is unchanged by a data grant made while if_req=0.
- Stall outputs:
  - if_stall = if_req & ~if_valid.
  - d_stall = d_req & ~d_valid.
  - Both are combinational from registered state and inputs.
- Latency: a request sampled in IDLE at edge N gives mem_req=1 in cycle N+1. With zero wait states, valid is high in cycle N+2.
- Back-to-back throughput is one transaction per 3 cycles plus memory wait states.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ready=1 first BUSY cycle, mem_rdata=0x00000013 -> mem_req high 1 cycle with mem_addr=0x100, mem_we=0; if_valid pulses 2 cycles after the request edge with if_rdata=0x00000013.
- Store with wait states: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_sign_mask=4'b0010, mem_ready after 4 cycles -> mem_* stable for all 4 BUSY cycles; d_valid=1 with d_rdata=0; d_stall high until d_valid.
- Simultaneous requests: if_req=d_req=1 at IDLE -> data granted first; fetch granted next after RESP/IDLE.
- Starvation, STARVE_LIMIT=3: d_req held permanently with new loads and if_req=1 -> exactly 3 data grants, then a fetch grant, after which starve_cnt reads 0.
- Reset mid-BUSY: reset_n low while mem_req=1 -> mem_req, if_valid and d_valid are 0 immediately; after release the FSM is in IDLE and re-arbitrates normally.
- Address change after grant: d_addr changes from 0x40 to 0x80 during BUSY -> mem_addr stays 0x40.
